mul_seq_ctrl: RTL
=================

// Module: mul_seq_ctrl
// PURPOSE
//   Sequential shift-add multiplier with controller. Computes x*y (unsigned) over WIDTH cycles.
//   Each cycle adds one partial product, through a single shared adder.
//   Sits beside the combinational multipliers as their area-lean counterpart.
//   Host handshake is start/busy/done.
// PARAMETERS
//   WIDTH   3   operand width in bits; result is 2*WIDTH bits
// PORTS
//   clk     in   1          clock; all state changes on rising edge
//   rst     in   1          asynchronous, active-high reset
//   start   in   1          request; sampled only in IDLE
//   x       in   WIDTH      multiplicand; captured when start is accepted
//   y       in   WIDTH      multiplier; captured when start is accepted
//   busy    out  1          high while in BUSY
//   done    out  1          one-cycle pulse; out is valid in that cycle
//   out     out  2*WIDTH    last completed product; held until next completion
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, busy=0, done=0, out=0, all internal registers cleared.
//   Internal registers: mcand[2W-1:0], mplr[W-1:0], acc[2W-1:0], cnt[clog2(W)-1:0].
//   IDLE: on start=1:
//     mcand<={W'b0,x}, mplr<=y, acc<=0, cnt<=0, go to BUSY.
//     start=0: stay in IDLE.
//   BUSY, every cycle:
//     acc <= acc + (mplr[0] ? mcand : 0); mcand <= mcand<<1; mplr <= mplr>>1; cnt <= cnt+1.
//     Exit when cnt==W-1: out <= acc + (mplr[0] ? mcand : 0); go to DONE.
//   DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//   Latency: start accepted at edge 0; BUSY for W cycles; done high in cycle W+1.
//     Next start is accepted in cycle W+2.
//   start while BUSY or DONE: ignored; it is not queued.
//   x/y changing after acceptance: no effect.
//   Width: all adds are 2W bits wide; no overflow is possible, since the max is (2^W-1)^2.
//   out is written only on the BUSY->DONE edge; it is not cleared by a new start.
//   Reset mid-operation: result discarded; out=0; busy/done drop asynchronously.
// CONFIGURATION
//   MUL_SEQ_EARLY_EXIT_EN defined:
//     BUSY also exits when mplr[W-1:1]==0, i.e. no set bits remain after the current one.
//     BUSY lasts max(1, index of highest set bit of y + 1) cycles.
//     y=0 or y=1 gives 1 BUSY cycle. out and done semantics are unchanged.
//   Not defined: BUSY always lasts exactly W cycles; latency is data-independent.
// STRUCTURE
//   mul_seq_pkg holds:
//     - state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE
//     - clog2 constant function for cnt width
//   Sub-module mul_seq_step (combinational):
//     in: acc, mcand, bit; out: acc + (bit ? mcand : 0).
//     Used for both the acc update and the out load, so there is one adder only.
//   Top: FSM + datapath registers.
// TESTING
//   Reset: assert rst mid-run -> busy=0, done=0, out=0 immediately, before any clock edge;
//     after release the FSM is in IDLE.
//   7*7 (W=3), EN off -> busy for 3 cycles, done pulses in cycle 4, out=49; out holds 49 afterwards.
//   5*0, EN off -> 3 BUSY cycles, out=0.
//     Same with EN on -> 1 BUSY cycle, out=0.
//   3*4, EN on -> 3 BUSY cycles, out=12.
//     3*1, EN on -> 1 BUSY cycle, out=3.
//   start held high continuously -> back-to-back ops;
//     start pulses during BUSY/DONE ignored; each op takes W+2 cycles, start edge to next acceptance.
//   Exhaustive: all 64 (x,y) pairs at W=3, both configs -> out==x*y.
//     done exactly one cycle per op; busy==(state==BUSY).

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state codes
// and the counter-width helper.
package mul_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned t;
    r = 0;
    t = (v > 0) ? v - 1 : 0;
    while (t != 0) begin
      r = r + 1;
      t = t >> 1;
    end
    return r;
  endfunction

  // Counter needs at least one bit even for a 1-bit operand.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (clog2(w) == 0) ? 1 : clog2(w);
  endfunction

endpackage

// File: rtl/mul_seq_step.sv
// One shift-add step: accumulate the multiplicand when the current multiplier
// bit is set. The only adder in the multiplier.
module mul_seq_step #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic               sel,
  output logic [2*WIDTH-1:0] sum_c
);

  assign sum_c = acc + (sel ? mcand : '0);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier with start/busy/done handshake.
// Optional MUL_SEQ_EARLY_EXIT_EN ends BUSY once no multiplier bits remain.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  logic [1:0]       state, state_next;
  logic [PW-1:0]    mcand, mcand_next;
  logic [WIDTH-1:0] mplr, mplr_next;
  logic [PW-1:0]    acc, acc_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [PW-1:0]    out_next;
  logic             busy_next, done_next;
  logic [PW-1:0]    sum_c;
  logic             last_c;

  mul_seq_step #(.WIDTH(WIDTH)) u_step (
    .acc   (acc),
    .mcand (mcand),
    .sel   (mplr[0]),
    .sum_c (sum_c)
  );

`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign last_c = (cnt == CW'(WIDTH - 1)) || ((mplr >> 1) == '0);
`else
  assign last_c = (cnt == CW'(WIDTH - 1));
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      mcand <= mcand_next;
      mplr  <= mplr_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      out   <= out_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    mcand_next = mcand;
    mplr_next  = mplr;
    acc_next   = acc;
    cnt_next   = cnt;
    out_next   = out;
    case (state)
      ST_IDLE: begin
        if (start) begin
          mcand_next = {{WIDTH{1'b0}}, x};
          mplr_next  = y;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_next   = sum_c;
        mcand_next = mcand << 1;
        mplr_next  = mplr >> 1;
        cnt_next   = cnt + CW'(1);
        if (last_c) begin
          out_next   = sum_c;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next == ST_BUSY);
    done_next = (state_next == ST_DONE);
  end

endmodule
